ex_mem_stage: RTL

EX_MEM_STAGE -- requirements
Module: ex_mem_stage

---
 rtl/ex_mem_stage.sv | 115 +++++++++++
 1 files changed

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with stall/flush control, plus the operand
// forwarding selects and load-use hazard detect that depend on its contents.
module ex_mem_stage #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         stall,
    input  logic         flush,
    input  logic         ex_valid,
    input  logic [N-1:0] alu_result,
    input  logic [N-1:0] store_data,
    input  logic [4:0]   dest_reg,
    input  logic         ctl_reg_write,
    input  logic         ctl_mem_read,
    input  logic         ctl_mem_write,
    input  logic         ctl_mem_to_reg,
    input  logic [4:0]   ex_rs,
    input  logic [4:0]   ex_rt,
    input  logic [4:0]   wb_rd,
    input  logic         wb_reg_write,
    output logic [N-1:0] mem_alu_result,
    output logic [N-1:0] mem_store_data,
    output logic [4:0]   mem_dest_reg,
    output logic         mem_reg_write,
    output logic         mem_mem_read,
    output logic         mem_mem_write,
    output logic         mem_mem_to_reg,
    output logic         mem_valid,
    output logic         mem_zero,
    output logic [1:0]   fwd_a,
    output logic [1:0]   fwd_b,
    output logic         load_hazard
);

    logic [N-1:0] alu_reg;
    logic [N-1:0] store_reg;
    logic [4:0]   dest_reg_q;
    logic         reg_write_reg;
    logic         mem_read_reg;
    logic         mem_write_reg;
    logic         mem_to_reg_reg;
    logic         valid_reg;
    logic         zero_reg;

    // Flush beats stall; a bubble carries no control, no data and no zero flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alu_reg        <= '0;
            store_reg      <= '0;
            dest_reg_q     <= '0;
            reg_write_reg  <= 1'b0;
            mem_read_reg   <= 1'b0;
            mem_write_reg  <= 1'b0;
            mem_to_reg_reg <= 1'b0;
            valid_reg      <= 1'b0;
            zero_reg       <= 1'b0;
        end else if (flush) begin
            alu_reg        <= '0;
            store_reg      <= '0;
            dest_reg_q     <= '0;
            reg_write_reg  <= 1'b0;
            mem_read_reg   <= 1'b0;
            mem_write_reg  <= 1'b0;
            mem_to_reg_reg <= 1'b0;
            valid_reg      <= 1'b0;
            zero_reg       <= 1'b0;
        end else if (!stall) begin
            alu_reg        <= alu_result;
            store_reg      <= store_data;
            dest_reg_q     <= dest_reg;
            reg_write_reg  <= ex_valid & ctl_reg_write;
            mem_read_reg   <= ex_valid & ctl_mem_read;
            mem_write_reg  <= ex_valid & ctl_mem_write;
            mem_to_reg_reg <= ex_valid & ctl_mem_to_reg;
            valid_reg      <= ex_valid;
            zero_reg       <= (alu_result == '0);
        end
    end

    assign mem_alu_result = alu_reg;
    assign mem_store_data = store_reg;
    assign mem_dest_reg   = dest_reg_q;
    assign mem_reg_write  = reg_write_reg;
    assign mem_mem_read   = mem_read_reg;
    assign mem_mem_write  = mem_write_reg;
    assign mem_mem_to_reg = mem_to_reg_reg;
    assign mem_valid      = valid_reg;
    assign mem_zero       = zero_reg;

    // A load's result is not ready in MEM, so it is never an EX/MEM forward source.
    logic            mem_fwd_ok;
    logic            wb_fwd_ok;
    logic [1:0][4:0] src_reg;
    logic [1:0][1:0] fwd_sel;

    assign mem_fwd_ok = valid_reg & reg_write_reg & ~mem_read_reg & (dest_reg_q != 5'd0);
    assign wb_fwd_ok  = wb_reg_write & (wb_rd != 5'd0);
    assign src_reg    = {ex_rt, ex_rs};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fwd
            assign fwd_sel[gi] = (mem_fwd_ok && dest_reg_q == src_reg[gi]) ? 2'b10 :
                                 (wb_fwd_ok  && wb_rd      == src_reg[gi]) ? 2'b01 : 2'b00;
        end
    endgenerate

    assign fwd_a = fwd_sel[0];
    assign fwd_b = fwd_sel[1];

    assign load_hazard = valid_reg & mem_read_reg & (dest_reg_q != 5'd0) &
                         ((dest_reg_q == ex_rs) | (dest_reg_q == ex_rt));

endmodule
